// File: rtl/tt_sweep_capture.sv
// Purpose: sweeps minterms 0..255 into an 8-input netlist and captures y0 into a 256-bit truth table.
// Latency: 256+LAT cycles from accepted start to done; rd_data is one cycle after rd_addr.
// Backpressure: none; start is ignored while a sweep or drain is in flight.
//
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   start            sweep request, accepted only in IDLE or DONE
//   busy, done       busy in SWEEP/DRAIN, done held in DONE
//   x_out            minterm driven to the netlist under test
//   y_in             netlist output, sampled LAT+1 edges after its minterm was driven
//   onset_cnt        number of captured minterms with y0=1
//   rd_addr, rd_data registered 32-bit word read of the truth table
module tt_sweep_capture #(
    parameter int LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [7:0]  x_out,
    input  logic        y_in,
    output logic [8:0]  onset_cnt,
    input  logic [2:0]  rd_addr,
    output logic [31:0] rd_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     x_q, x_d;
    logic [7:0]     smp_q, smp_d;
    logic [8:0]     onset_q, onset_d;
    logic [255:0]   tt_q, tt_d;
    logic [LAT:0]   vld_q, vld_d;
    logic [2:0]     drain_q, drain_d;
    logic [31:0]    rd_q, rd_d;
    logic           go;
    logic           smp_vld;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        smp_d   = smp_q;
        onset_d = onset_q;
        tt_d    = tt_q;
        drain_d = drain_q;
        go      = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        // Bit k of the delay line is set when the minterm driven k cycles
        // ago was live; the top bit marks the sample landing on this edge.
        smp_vld = vld_q[LAT];
        // Read uses the pre-update table: no write-to-read bypass.
        rd_d    = tt_q[{rd_addr, 5'b00000} +: 32];

        if (smp_vld) begin
            tt_d[smp_q] = y_in;
            onset_d     = onset_q + {8'd0, y_in};
            smp_d       = smp_q + 8'd1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    state_d = S_SWEEP;
                    x_d     = 8'd0;
                    smp_d   = 8'd0;
                    onset_d = 9'd0;
                    tt_d    = '0;
                end
            end
            S_SWEEP: begin
                if (x_q == 8'hFF) begin
                    state_d = (LAT == 0) ? S_DONE : S_DRAIN;
                    drain_d = 3'd0;
                end else begin
                    x_d = x_q + 8'd1;
                end
            end
            S_DRAIN: begin
                // Exactly LAT cycles so the last in-flight samples land.
                if (drain_q == 3'(LAT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A cycle carries a live minterm exactly when the FSM is in SWEEP.
        vld_d = (vld_q << 1) | (LAT + 1)'(state_d == S_SWEEP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= 8'd0;
            smp_q   <= 8'd0;
            onset_q <= 9'd0;
            tt_q    <= '0;
            vld_q   <= '0;
            drain_q <= 3'd0;
            rd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            smp_q   <= smp_d;
            onset_q <= onset_d;
            tt_q    <= tt_d;
            vld_q   <= vld_d;
            drain_q <= drain_d;
            rd_q    <= rd_d;
        end
    end

    assign busy      = (state_q == S_SWEEP) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign x_out     = x_q;
    assign onset_cnt = onset_q;
    assign rd_data   = rd_q;

endmodule
